// File: rtl/fc_seq_ctrl.sv
// Fully-connected layer sequencer: streams features and weights, one signed MAC per cycle.
// Latency: N_IN+2 cycles per neuron with prob_ready high; done pulses one cycle after the last score.
// Backpressure: prob_ready low holds the score in EMIT and issues no reads until it is accepted.
module fc_seq_ctrl #(
  parameter int N_IN     = 1152,
  parameter int N_OUT    = 10,
  parameter int DATA_W   = 69,
  parameter int WEIGHT_W = 32,
  parameter int ACC_W    = 101,
  parameter int OUT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                feat_rd_en,
  output logic [10:0]         feat_addr,
  input  logic [DATA_W-1:0]   feat_data,
  output logic                wt_rd_en,
  output logic [13:0]         wt_addr,
  input  logic [WEIGHT_W-1:0] wt_data,
  output logic                prob_valid,
  output logic [3:0]          prob_idx,
  output logic [OUT_W-1:0]    prob_data,
  input  logic                prob_ready
);

  localparam logic [10:0] M_LAST = 11'(N_IN - 1);
  localparam logic [3:0]  N_LAST = 4'(N_OUT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, FIN} state_t;

  state_t             state;
  logic [10:0]        m;
  logic [3:0]         n;
  logic [ACC_W-1:0]   acc;
  logic               rd_en;
  logic               rd_dly;
  logic [ACC_W-1:0]   w_ext;
  logic [ACC_W-1:0]   f_ext;
  logic [ACC_W-1:0]   prod;
  logic [ACC_W-1:0]   acc_nxt;

  assign feat_rd_en = rd_en;
  assign wt_rd_en   = rd_en;
  assign feat_addr  = m;

  // Accumulation is modulo 2^ACC_W, so an ACC_W-wide product of the extended operands is exact.
  always_comb begin
    w_ext   = {{(ACC_W-WEIGHT_W){wt_data[WEIGHT_W-1]}}, wt_data};
    f_ext   = {{(ACC_W-DATA_W){1'b0}}, feat_data};
    prod    = w_ext * f_ext;
    acc_nxt = rd_dly ? acc + prod : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      m          <= '0;
      n          <= '0;
      acc        <= '0;
      rd_en      <= 1'b0;
      rd_dly     <= 1'b0;
      wt_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      prob_valid <= 1'b0;
      prob_idx   <= '0;
      prob_data  <= '0;
    end else begin
      rd_dly <= rd_en;
      acc    <= acc_nxt;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            n       <= '0;
            m       <= '0;
            acc     <= '0;
            wt_addr <= '0;
            rd_en   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          if (m == M_LAST) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            m       <= m + 11'd1;
            wt_addr <= wt_addr + 14'd1;
          end
        end
        DRAIN: begin
          // The last product lands this cycle, so the score is taken from acc_nxt.
          state      <= EMIT;
          prob_valid <= 1'b1;
          prob_idx   <= n;
          prob_data  <= acc_nxt[ACC_W-1 -: OUT_W];
        end
        EMIT: begin
          if (prob_ready) begin
            prob_valid <= 1'b0;
            if (n == N_LAST) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= FETCH;
              n       <= n + 4'd1;
              m       <= '0;
              acc     <= '0;
              wt_addr <= wt_addr + 14'd1;
              rd_en   <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed bench for fc_seq_ctrl with synchronous feature/weight memory models.
module tb_fc_seq_ctrl;

  localparam int N_IN     = 1152;
  localparam int N_OUT    = 10;
  localparam int DATA_W   = 69;
  localparam int WEIGHT_W = 32;
  localparam int ACC_W    = 101;
  localparam int OUT_W    = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                busy;
  logic                done;
  logic                feat_rd_en;
  logic [10:0]         feat_addr;
  logic [DATA_W-1:0]   feat_data = '0;
  logic                wt_rd_en;
  logic [13:0]         wt_addr;
  logic [WEIGHT_W-1:0] wt_data = '0;
  logic                prob_valid;
  logic [3:0]          prob_idx;
  logic [OUT_W-1:0]    prob_data;
  logic                prob_ready = 1'b1;

  logic [DATA_W-1:0]   feat_mem [N_IN];
  logic [WEIGHT_W-1:0] wt_mem   [N_OUT*N_IN];

  int checks = 0;
  int errors = 0;

  fc_seq_ctrl #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W),
    .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .feat_rd_en(feat_rd_en), .feat_addr(feat_addr), .feat_data(feat_data),
    .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_data(wt_data),
    .prob_valid(prob_valid), .prob_idx(prob_idx), .prob_data(prob_data),
    .prob_ready(prob_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (feat_rd_en) feat_data <= feat_mem[feat_addr];
    if (wt_rd_en)   wt_data   <= wt_mem[wt_addr];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 1: all ones; mode 2: feat[0]=2^69-1, wt row n = {n+1,0..}; mode 3: feat[0]=2^68, weights -2
  task automatic load_mem(input int mode);
    for (int i = 0; i < N_IN; i++) begin
      case (mode)
        1:       feat_mem[i] = 69'd1;
        2:       feat_mem[i] = (i == 0) ? {DATA_W{1'b1}} : 69'd5;
        default: feat_mem[i] = (i == 0) ? {1'b1, 68'd0} : 69'd0;
      endcase
    end
    for (int i = 0; i < N_OUT*N_IN; i++) begin
      case (mode)
        1:       wt_mem[i] = 32'd1;
        2:       wt_mem[i] = (i % N_IN == 0) ? 32'(i / N_IN + 1) : 32'd0;
        default: wt_mem[i] = 32'hFFFF_FFFE;
      endcase
    end
  endtask

  function automatic logic [OUT_W-1:0] exp_data(input int mode, input int idx);
    case (mode)
      1:       return 32'd0;
      2:       return 32'(idx);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [65:0] all_outs();
    return {busy, done, feat_rd_en, feat_addr, wt_rd_en, wt_addr,
            prob_valid, prob_idx, prob_data};
  endfunction

  // abort_n >= 0 asserts rst_n while fetching neuron abort_n at m=600.
  task automatic run(input int mode, input bit stall_en, input bit pulse_en,
                     input int abort_n, input int exp_done, input string nm);
    int   xfers = 0, dones = 0, done_c = 0, first_c = 0;
    int   viol = 0, stall_viol = 0, stall_left = 0;
    bit   stalled = 0, chk_next = 0, aborted = 0;
    logic [36:0] snap = '0;
    load_mem(mode);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= 13000; c++) begin
      if ((prob_valid && feat_rd_en) || (prob_valid && done) || (feat_rd_en && done)) viol++;
      if (feat_rd_en !== wt_rd_en) viol++;
      if (feat_rd_en && int'(wt_addr) != xfers*N_IN + int'(feat_addr)) viol++;
      if (chk_next) begin
        chk({nm, " fetch after stall"}, {feat_rd_en, feat_addr, wt_addr},
            {1'b1, 11'd0, 14'(4*N_IN)});
        chk_next = 0;
      end
      start = pulse_en && (c == 100);
      if (pulse_en && done) start = 1'b1;
      if (stall_en && !stalled && prob_valid && prob_idx == 4'd3) begin
        stalled    = 1;
        stall_left = 5;
        prob_ready = 1'b0;
        snap       = {prob_valid, prob_idx, prob_data};
      end else if (stall_left > 0) begin
        if ({prob_valid, prob_idx, prob_data} !== snap || feat_rd_en || wt_rd_en) stall_viol++;
        stall_left--;
        if (stall_left == 0) prob_ready = 1'b1;
      end
      if (prob_valid && prob_ready) begin
        if (xfers == 0) first_c = c;
        chk({nm, " idx"}, prob_idx, xfers);
        chk({nm, " data"}, prob_data, exp_data(mode, xfers));
        if (stall_en && xfers == 3) chk_next = 1;
        xfers++;
      end
      if (done) begin
        dones++;
        done_c = c;
      end
      if (abort_n >= 0 && xfers == abort_n && feat_rd_en && feat_addr == 11'd600) begin
        rst_n = 1'b0;
        #1;
        chk({nm, " outputs on reset"}, all_outs(), '0);
        aborted = 1;
        @(negedge clk) rst_n = 1'b1;
        break;
      end
      if (done_c != 0 && c >= done_c + 20) break;
      @(negedge clk);
    end
    start = 1'b0;
    prob_ready = 1'b1;
    if (aborted) begin
      chk({nm, " done count"}, dones, 0);
      chk({nm, " idle after abort"}, {busy, feat_rd_en, prob_valid}, 3'b000);
    end else begin
      chk({nm, " transfers"}, xfers, N_OUT);
      chk({nm, " done count"}, dones, 1);
      chk({nm, " first valid cycle"}, first_c, N_IN + 2);
      chk({nm, " done cycle"}, done_c, exp_done);
      chk({nm, " invariants"}, viol, 0);
      chk({nm, " idle after run"}, {busy, feat_rd_en, prob_valid, done}, 4'b0000);
      if (stall_en) begin
        chk({nm, " stall seen"}, stalled, 1'b1);
        chk({nm, " stall hold"}, stall_viol, 0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", all_outs(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle before start", all_outs(), '0);
    run(1, 1'b1, 1'b1, -1, N_OUT*(N_IN+2) + 1 + 5, "ones");
    run(3, 1'b0, 1'b0, -1, N_OUT*(N_IN+2) + 1, "negative");
    run(2, 1'b0, 1'b0, 5, 0, "abort");
    run(2, 1'b0, 1'b0, -1, N_OUT*(N_IN+2) + 1, "maxfeat");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
